// File: rtl/ssc_pkg.sv
// Shared types and widths for the single-cycle core's writeback path.
// Used by the writeback unit, SSCRegisterBank and the execute stage.
package ssc_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 3;
   localparam int FLAG_W = 4;

   typedef struct packed {
      logic              write_reg;
      logic              set_flags;
      logic [REG_AW-1:0] dest;
      logic [DATA_W-1:0] data;
      logic [FLAG_W-1:0] flags;
   } wb_entry_t;

   // An entry that neither writes a register nor loads flags has no effect on the bank.
   function automatic logic wbHasEffect(wb_entry_t e);
      return e.write_reg || e.set_flags;
   endfunction

endpackage

// File: rtl/ssc_wb_fifo.sv
// Synchronous FIFO of writeback entries with an ordered head-to-tail view,
// so the forwarding scan can see every queued entry in the same cycle.
module ssc_wb_fifo
   import ssc_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Push,
   input  wb_entry_t              PushEntry,
   input  logic                   Pop,
   output logic [CW-1:0]          Count,
   output logic                   Full,
   output logic                   Empty,
   output wb_entry_t [DEPTH-1:0]  EntryView,
   output logic [DEPTH-1:0]       ValidView
);

   wb_entry_t       mem [DEPTH];
   logic [AW-1:0]   wrPtr;
   logic [AW-1:0]   rdPtr;
   logic            pushOk;
   logic            popOk;

   assign Full   = (Count == CW'(DEPTH));
   assign Empty  = (Count == '0);
   assign pushOk = Push && !Full;
   assign popOk  = Pop && !Empty;

   // Storage is left unreset; ValidView masks stale slots from the scan.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         Count <= '0;
      end else begin
         if (pushOk) begin
            mem[wrPtr] <= PushEntry;
            wrPtr      <= wrPtr + 1'b1;
         end
         if (popOk) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushOk, popOk})
            2'b10:   Count <= Count + 1'b1;
            2'b01:   Count <= Count - 1'b1;
            default: Count <= Count;
         endcase
      end
   end

   // View index 0 is the head (oldest), DEPTH-1 the newest possible slot.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         EntryView[i] = mem[rdPtr + AW'(i)];
         ValidView[i] = (CW'(i) < Count);
      end
   end

endmodule

// File: rtl/ssc_writeback_unit.sv
// Buffered writeback unit owning the register bank write port: queues updates,
// retires one per cycle and forwards pending register values to operand fetch.
module ssc_writeback_unit
   import ssc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = ssc_pkg::DATA_W,
   parameter int REG_AW = ssc_pkg::REG_AW,
   parameter int FLAG_W = ssc_pkg::FLAG_W,
   localparam int PW = $clog2(DEPTH + 2),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Clk_Enable,
   input  logic              Req_Valid,
   output logic              Req_Ready,
   input  logic              Req_WriteReg,
   input  logic [REG_AW-1:0] Req_DestReg,
   input  logic [DATA_W-1:0] Req_Data,
   input  logic              Req_SetFlags,
   input  logic [FLAG_W-1:0] Req_Flags,
   input  logic              Drain_Stall,
   output logic              wEnable,
   output logic [REG_AW-1:0] DestReg,
   output logic [DATA_W-1:0] WBDataIN,
   output logic              SetFlags,
   output logic [FLAG_W-1:0] BRFlags,
   input  logic [REG_AW-1:0] OpReg1,
   input  logic [REG_AW-1:0] OpReg2,
   output logic              Fwd1_Hit,
   output logic              Fwd2_Hit,
   output logic [DATA_W-1:0] Fwd1_Data,
   output logic [DATA_W-1:0] Fwd2_Data,
   output logic [PW-1:0]     Pending,
   output logic              Empty
);

   // Handshake: a request transfers at the rising edge where Req_Valid && Req_Ready;
   // Req_Ready depends only on registered state, never on Req_Valid.

   wb_entry_t             reqEntry;
   wb_entry_t             outEntry;
   logic                  outValid;
   logic                  accept;
   logic                  push;
   logic                  loadOut;
   logic                  pop;
   logic [CW-1:0]         fifoCount;
   logic                  fifoFull;
   logic                  fifoEmpty;
   wb_entry_t [DEPTH-1:0] entryView;
   logic [DEPTH-1:0]      validView;

   assign reqEntry = '{write_reg: Req_WriteReg, set_flags: Req_SetFlags,
                       dest: Req_DestReg, data: Req_Data, flags: Req_Flags};

   // Full FIFO refuses even when the head is leaving this cycle.
   assign Req_Ready = !Reset && Clk_Enable && !fifoFull;
   assign accept    = Req_Valid && Req_Ready;
   assign push      = accept && wbHasEffect(reqEntry);

   assign loadOut = Clk_Enable && !Reset && (!outValid || !Drain_Stall);
   assign pop     = loadOut && !fifoEmpty;

   ssc_wb_fifo #(.DEPTH(DEPTH)) uFifo (
      .Clk       (Clk),
      .Reset     (Reset),
      .Push      (push),
      .PushEntry (reqEntry),
      .Pop       (pop),
      .Count     (fifoCount),
      .Full      (fifoFull),
      .Empty     (fifoEmpty),
      .EntryView (entryView),
      .ValidView (validView)
   );

   // Output stage keeps its last contents when it empties, so bank inputs hold.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         outValid <= 1'b0;
         outEntry <= '0;
      end else if (loadOut) begin
         if (!fifoEmpty) begin
            outValid <= 1'b1;
            outEntry <= entryView[0];
         end else begin
            outValid <= 1'b0;
         end
      end
   end

   assign wEnable  = outValid && outEntry.write_reg && !Drain_Stall && Clk_Enable && !Reset;
   assign SetFlags = outValid && outEntry.set_flags && !Drain_Stall && Clk_Enable && !Reset;
   assign DestReg  = outEntry.dest;
   assign WBDataIN = outEntry.data;
   assign BRFlags  = outEntry.flags;

   assign Pending = PW'(fifoCount) + PW'(outValid);
   assign Empty   = (Pending == '0);

   // Scan oldest to newest so a later match overrides an earlier one.
   always_comb begin
      Fwd1_Hit  = 1'b0;
      Fwd2_Hit  = 1'b0;
      Fwd1_Data = '0;
      Fwd2_Data = '0;
      if (outValid && outEntry.write_reg) begin
         if (outEntry.dest == OpReg1) begin
            Fwd1_Hit  = 1'b1;
            Fwd1_Data = outEntry.data;
         end
         if (outEntry.dest == OpReg2) begin
            Fwd2_Hit  = 1'b1;
            Fwd2_Data = outEntry.data;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (validView[i] && entryView[i].write_reg) begin
            if (entryView[i].dest == OpReg1) begin
               Fwd1_Hit  = 1'b1;
               Fwd1_Data = entryView[i].data;
            end
            if (entryView[i].dest == OpReg2) begin
               Fwd2_Hit  = 1'b1;
               Fwd2_Data = entryView[i].data;
            end
         end
      end
   end

endmodule

// File: tb/tb_ssc_writeback_unit.sv
// Directed bench for ssc_writeback_unit: latency, backpressure, forwarding,
// flag-only entries, mid-run reset and clock-enable freeze.
module tb_ssc_writeback_unit;

   logic        Clk;
   logic        Reset;
   logic        Clk_Enable;
   logic        Req_Valid;
   logic        Req_Ready;
   logic        Req_WriteReg;
   logic [2:0]  Req_DestReg;
   logic [31:0] Req_Data;
   logic        Req_SetFlags;
   logic [3:0]  Req_Flags;
   logic        Drain_Stall;
   logic        wEnable;
   logic [2:0]  DestReg;
   logic [31:0] WBDataIN;
   logic        SetFlags;
   logic [3:0]  BRFlags;
   logic [2:0]  OpReg1;
   logic [2:0]  OpReg2;
   logic        Fwd1_Hit;
   logic        Fwd2_Hit;
   logic [31:0] Fwd1_Data;
   logic [31:0] Fwd2_Data;
   logic [2:0]  Pending;
   logic        Empty;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] expWord;

   ssc_writeback_unit #(.DEPTH(4)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Clk_Enable   (Clk_Enable),
      .Req_Valid    (Req_Valid),
      .Req_Ready    (Req_Ready),
      .Req_WriteReg (Req_WriteReg),
      .Req_DestReg  (Req_DestReg),
      .Req_Data     (Req_Data),
      .Req_SetFlags (Req_SetFlags),
      .Req_Flags    (Req_Flags),
      .Drain_Stall  (Drain_Stall),
      .wEnable      (wEnable),
      .DestReg      (DestReg),
      .WBDataIN     (WBDataIN),
      .SetFlags     (SetFlags),
      .BRFlags      (BRFlags),
      .OpReg1       (OpReg1),
      .OpReg2       (OpReg2),
      .Fwd1_Hit     (Fwd1_Hit),
      .Fwd2_Hit     (Fwd2_Hit),
      .Fwd1_Data    (Fwd1_Data),
      .Fwd2_Data    (Fwd2_Data),
      .Pending      (Pending),
      .Empty        (Empty)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   task automatic drive_req(input logic wr, input logic [2:0] dest, input logic [31:0] data,
                            input logic sf, input logic [3:0] flags);
      Req_Valid    = 1'b1;
      Req_WriteReg = wr;
      Req_DestReg  = dest;
      Req_Data     = data;
      Req_SetFlags = sf;
      Req_Flags    = flags;
   endtask

   task automatic idle_req();
      Req_Valid    = 1'b0;
      Req_WriteReg = 1'b0;
      Req_SetFlags = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Clk_Enable = 1'b1; Drain_Stall = 1'b0;
      OpReg1 = 3'd0; OpReg2 = 3'd0;
      Req_DestReg = 3'd0; Req_Data = 32'h0; Req_Flags = 4'h0;
      idle_req();
      step();
      step();

      // Reset state
      chk("rst_ready",   {31'b0, Req_Ready}, 32'd0);
      chk("rst_pending", {29'b0, Pending},   32'd0);
      chk("rst_empty",   {31'b0, Empty},     32'd1);
      chk("rst_wen",     {31'b0, wEnable},   32'd0);
      chk("rst_setf",    {31'b0, SetFlags},  32'd0);
      chk("rst_dest",    {29'b0, DestReg},   32'd0);
      chk("rst_data",    WBDataIN,           32'd0);
      chk("rst_flags",   {28'b0, BRFlags},   32'd0);

      // Single request latency
      Reset = 1'b0;
      drive_req(1'b1, 3'd3, 32'h0000FFFF, 1'b0, 4'h0);
      #1;
      chk("lat_ready", {31'b0, Req_Ready}, 32'd1);
      step();
      idle_req();
      #1;
      chk("lat_e1_wen",  {31'b0, wEnable}, 32'd0);
      chk("lat_e1_pend", {29'b0, Pending}, 32'd1);
      step();
      chk("lat_e2_wen",  {31'b0, wEnable}, 32'd1);
      chk("lat_e2_dest", {29'b0, DestReg}, 32'd3);
      chk("lat_e2_data", WBDataIN,         32'h0000FFFF);
      step();
      chk("lat_empty",   {31'b0, Empty},   32'd1);
      chk("lat_wen_off", {31'b0, wEnable}, 32'd0);
      chk("lat_hold",    {29'b0, DestReg}, 32'd3);

      // Dropped request has no effect
      drive_req(1'b0, 3'd1, 32'h55, 1'b0, 4'h0);
      step();
      idle_req();
      #1;
      chk("drop_pend", {29'b0, Pending}, 32'd0);

      // Backpressure with 5 entries under stall
      Drain_Stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         expWord = 32'hEEEE - 32'h1111 * i;
         drive_req(1'b1, 3'(2 + i), expWord, 1'b0, 4'h0);
         exp_q.push_back({13'b0, 3'(2 + i), expWord[15:0]});
         #1;
         chk("bp_ready", {31'b0, Req_Ready}, 32'd1);
         step();
      end
      idle_req();
      #1;
      chk("bp_full_ready", {31'b0, Req_Ready}, 32'd0);
      chk("bp_pending",    {29'b0, Pending},   32'd5);
      chk("bp_wen_stall",  {31'b0, wEnable},   32'd0);
      step();
      chk("bp_wen_stall2", {31'b0, wEnable},   32'd0);
      chk("bp_pending2",   {29'b0, Pending},   32'd5);
      Drain_Stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         expWord = exp_q.pop_front();
         #1;
         chk("bp_drain_wen",  {31'b0, wEnable}, 32'd1);
         chk("bp_drain_dest", {29'b0, DestReg}, {29'b0, expWord[18:16]});
         chk("bp_drain_data", WBDataIN,         {16'b0, expWord[15:0]});
         step();
      end
      chk("bp_empty", {31'b0, Empty}, 32'd1);

      // Forwarding: newest write to reg 5 wins, reg 7 misses
      Drain_Stall = 1'b1;
      OpReg1 = 3'd5; OpReg2 = 3'd7;
      drive_req(1'b1, 3'd5, 32'hCCCC, 1'b0, 4'h0);
      step();
      drive_req(1'b1, 3'd5, 32'h1234, 1'b0, 4'h0);
      step();
      idle_req();
      #1;
      chk("fwd1_hit",  {31'b0, Fwd1_Hit}, 32'd1);
      chk("fwd1_data", Fwd1_Data,         32'h1234);
      chk("fwd2_hit",  {31'b0, Fwd2_Hit}, 32'd0);
      chk("fwd2_data", Fwd2_Data,         32'd0);

      // Flag-only entry behind them
      drive_req(1'b0, 3'd5, 32'h9999, 1'b1, 4'b1010);
      step();
      idle_req();
      #1;
      chk("flg_fwd1_data", Fwd1_Data,         32'h1234);
      chk("flg_fwd2_hit",  {31'b0, Fwd2_Hit}, 32'd0);
      chk("flg_pending",   {29'b0, Pending},  32'd3);
      Drain_Stall = 1'b0;
      #1;
      chk("flg_d1_wen",  {31'b0, wEnable}, 32'd1);
      chk("flg_d1_data", WBDataIN,         32'hCCCC);
      chk("flg_d1_fwd",  Fwd1_Data,        32'h1234);
      step();
      chk("flg_d2_wen",  {31'b0, wEnable},  32'd1);
      chk("flg_d2_data", WBDataIN,          32'h1234);
      chk("flg_d2_hit",  {31'b0, Fwd1_Hit}, 32'd1);
      step();
      chk("flg_d3_setf",  {31'b0, SetFlags}, 32'd1);
      chk("flg_d3_flags", {28'b0, BRFlags},  32'b1010);
      chk("flg_d3_wen",   {31'b0, wEnable},  32'd0);
      chk("flg_d3_hit",   {31'b0, Fwd1_Hit}, 32'd0);
      step();
      chk("flg_empty", {31'b0, Empty}, 32'd1);

      // Reset with 3 pending discards them
      Drain_Stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         drive_req(1'b1, 3'(i), 32'h11 * i, 1'b0, 4'h0);
         step();
      end
      idle_req();
      #1;
      chk("mr_pending", {29'b0, Pending}, 32'd3);
      Drain_Stall = 1'b0;
      Reset = 1'b1;
      #1;
      chk("mr_wen_rst", {31'b0, wEnable}, 32'd0);
      step();
      Reset = 1'b0;
      #1;
      chk("mr_pend0", {29'b0, Pending}, 32'd0);
      chk("mr_empty", {31'b0, Empty},   32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("mr_no_wen", {31'b0, wEnable}, 32'd0);
         step();
      end

      // Clk_Enable low freezes 2 pending entries
      Drain_Stall = 1'b1;
      drive_req(1'b1, 3'd4, 32'h44, 1'b0, 4'h0);
      step();
      drive_req(1'b1, 3'd6, 32'h66, 1'b0, 4'h0);
      step();
      idle_req();
      Drain_Stall = 1'b0;
      Clk_Enable = 1'b0;
      OpReg1 = 3'd6; OpReg2 = 3'd4;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ce_pending", {29'b0, Pending},   32'd2);
         chk("ce_wen",     {31'b0, wEnable},   32'd0);
         chk("ce_ready",   {31'b0, Req_Ready}, 32'd0);
         chk("ce_fwd1",    Fwd1_Data,          32'h66);
         chk("ce_fwd2",    Fwd2_Data,          32'h44);
         step();
      end
      Clk_Enable = 1'b1;
      #1;
      chk("ce_r1_wen",  {31'b0, wEnable}, 32'd1);
      chk("ce_r1_dest", {29'b0, DestReg}, 32'd4);
      chk("ce_r1_data", WBDataIN,         32'h44);
      step();
      chk("ce_r2_wen",  {31'b0, wEnable}, 32'd1);
      chk("ce_r2_dest", {29'b0, DestReg}, 32'd6);
      chk("ce_r2_data", WBDataIN,         32'h66);
      step();
      chk("ce_empty", {31'b0, Empty}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
